// File: rtl/channel_exchanger_if.sv
// Sample bus between the alpha decision logic, the exchanger and the decimation path.
interface channel_exchanger_if #(
    parameter int unsigned W_HSNR = 12,
    parameter int unsigned W_HDR  = 9,
    parameter int unsigned W_OUT  = 13
);
    logic                     sample_valid;
    logic signed [W_HSNR-1:0] hsnr_value;
    logic signed [W_HDR-1:0]  hdr_value;
    logic                     alpha;
    logic signed [W_OUT-1:0]  out_value;
    logic                     out_valid;
    logic                     out_source;
    logic                     in_transition;

    // Upstream side: drives samples and mode request, observes the exchanged stream.
    modport master (
        output sample_valid, hsnr_value, hdr_value, alpha,
        input  out_value, out_valid, out_source, in_transition
    );

    // Exchanger side.
    modport slave (
        input  sample_valid, hsnr_value, hdr_value, alpha,
        output out_value, out_valid, out_source, in_transition
    );
endinterface

// File: rtl/channel_exchanger.sv
// HSNR/HDR channel exchanger: immediate switch into HDR, linear crossfade back to HSNR.
module channel_exchanger #(
    parameter int unsigned W_HSNR     = 12,
    parameter int unsigned W_HDR      = 9,
    parameter int unsigned GAIN_SHIFT = 3,
    parameter int unsigned W_OUT      = 13,
    parameter int unsigned XFADE_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    channel_exchanger_if.slave bus
);
    localparam int unsigned N     = 1 << XFADE_LOG2;
    localparam int unsigned W_MIX = W_OUT + XFADE_LOG2 + 1;

    typedef enum logic [1:0] {
        HSNR_SEL = 2'd0,
        HDR_SEL  = 2'd1,
        XFADE    = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [XFADE_LOG2-1:0]   k, k_next, k_mix;

    logic signed [W_OUT-1:0] hs, hd, mix;
    logic signed [W_MIX-1:0] hs_wide, hd_wide, w_hs, w_hd, acc;

    logic signed [W_OUT-1:0] out_value_q, out_value_next;
    logic                    out_valid_q, out_valid_next;
    logic                    out_source_q, out_source_next;
    logic                    in_transition_q, in_transition_next;

    // Gain-match both channels into the output format and form the crossfade mix for k+1.
    always_comb begin
        hs      = W_OUT'(bus.hsnr_value);
        hd      = W_OUT'(bus.hdr_value) <<< GAIN_SHIFT;
        k_mix   = k + XFADE_LOG2'(1);
        hs_wide = W_MIX'(hs);
        hd_wide = W_MIX'(hd);
        w_hd    = W_MIX'(N) - W_MIX'(k_mix);
        w_hs    = W_MIX'(k_mix);
        acc     = hd_wide * w_hd + hs_wide * w_hs;
        mix     = W_OUT'(acc >>> XFADE_LOG2);
    end

    // Next-state and output decision; everything advances only on a sample strobe.
    always_comb begin
        state_next         = state;
        k_next             = k;
        out_value_next     = out_value_q;
        out_source_next    = out_source_q;
        in_transition_next = in_transition_q;
        out_valid_next     = bus.sample_valid;

        case (state)
            HSNR_SEL: begin
                if (bus.sample_valid) begin
                    in_transition_next = 1'b0;
                    if (bus.alpha) begin
                        out_value_next  = hd;
                        out_source_next = 1'b1;
                        state_next      = HDR_SEL;
                    end else begin
                        out_value_next  = hs;
                        out_source_next = 1'b0;
                    end
                end
            end
            HDR_SEL: begin
                if (bus.sample_valid) begin
                    out_source_next = 1'b1;
                    if (bus.alpha) begin
                        out_value_next     = hd;
                        in_transition_next = 1'b0;
                    end else begin
                        k_next             = k_mix;
                        out_value_next     = mix;
                        in_transition_next = 1'b1;
                        state_next         = XFADE;
                    end
                end
            end
            XFADE: begin
                if (bus.sample_valid) begin
                    if (bus.alpha) begin
                        // Abort: back to HDR at once; a later exit restarts the full fade.
                        k_next             = '0;
                        out_value_next     = hd;
                        out_source_next    = 1'b1;
                        in_transition_next = 1'b0;
                        state_next         = HDR_SEL;
                    end else if (k == XFADE_LOG2'(N - 1)) begin
                        k_next             = '0;
                        out_value_next     = hs;
                        out_source_next    = 1'b0;
                        in_transition_next = 1'b0;
                        state_next         = HSNR_SEL;
                    end else begin
                        k_next             = k_mix;
                        out_value_next     = mix;
                        out_source_next    = 1'b1;
                        in_transition_next = 1'b1;
                    end
                end
            end
            default: begin
                // Illegal encoding: recover unconditionally, treat any strobe as HSNR.
                state_next = HSNR_SEL;
                k_next     = '0;
                if (bus.sample_valid) begin
                    out_value_next     = hs;
                    out_source_next    = 1'b0;
                    in_transition_next = 1'b0;
                end
            end
        endcase
    end

    // State, crossfade counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= HSNR_SEL;
            k               <= '0;
            out_value_q     <= '0;
            out_valid_q     <= 1'b0;
            out_source_q    <= 1'b0;
            in_transition_q <= 1'b0;
        end else begin
            state           <= state_next;
            k               <= k_next;
            out_value_q     <= out_value_next;
            out_valid_q     <= out_valid_next;
            out_source_q    <= out_source_next;
            in_transition_q <= in_transition_next;
        end
    end

    assign bus.out_value     = out_value_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_source    = out_source_q;
    assign bus.in_transition = in_transition_q;

endmodule

// File: tb/tb_channel_exchanger.sv
// Bench for channel_exchanger: directed vector table, hand sequences, random vs reference model.
module tb_channel_exchanger;
    localparam int unsigned W_HSNR     = 12;
    localparam int unsigned W_HDR      = 9;
    localparam int unsigned GAIN_SHIFT = 3;
    localparam int unsigned W_OUT      = 13;
    localparam int unsigned XFADE_LOG2 = 2;
    localparam int          NF         = 1 << XFADE_LOG2;

    typedef struct {
        bit alpha;
        int hsnr;
        int hdr;
        int out;
        bit src;
        bit trans;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    channel_exchanger_if #(.W_HSNR(W_HSNR), .W_HDR(W_HDR), .W_OUT(W_OUT)) bus ();

    channel_exchanger #(
        .W_HSNR(W_HSNR), .W_HDR(W_HDR), .GAIN_SHIFT(GAIN_SHIFT),
        .W_OUT(W_OUT), .XFADE_LOG2(XFADE_LOG2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: whether HDR is (still) contributing, and how many mixed samples emitted.
    bit m_hdr  = 1'b0;
    int m_fade = 0;
    int last_out  = 0;
    bit last_src  = 1'b0;
    bit last_trans = 1'b0;

    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_step(input bit a, input int hs, input int hdr_in,
                              output int eo, output bit es, output bit et);
        int hd;
        hd = hdr_in * (2 ** GAIN_SHIFT);
        if (a) begin
            m_hdr = 1'b1; m_fade = 0;
            eo = hd; es = 1'b1; et = 1'b0;
        end else if (!m_hdr) begin
            eo = hs; es = 1'b0; et = 1'b0;
        end else begin
            m_fade = m_fade + 1;
            if (m_fade == NF) begin
                m_hdr = 1'b0; m_fade = 0;
                eo = hs; es = 1'b0; et = 1'b0;
            end else begin
                eo = floordiv(hd * (NF - m_fade) + hs * m_fade, NF);
                es = 1'b1; et = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One strobe, called at a negedge; checks the result one cycle later.
    task automatic strobe(input string tag, input bit a, input int hs, input int hd,
                          input bit use_model, input int xo, input bit xs, input bit xt);
        int eo; bit es; bit et;
        model_step(a, hs, hd, eo, es, et);
        if (!use_model) begin
            eo = xo; es = xs; et = xt;
        end
        bus.sample_valid = 1'b1;
        bus.alpha        = a;
        bus.hsnr_value   = W_HSNR'(hs);
        bus.hdr_value    = W_HDR'(hd);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check({tag, " valid"}, int'(bus.out_valid), 1);
        check({tag, " out"},   int'(bus.out_value), eo);
        check({tag, " src"},   int'(bus.out_source), int'(es));
        check({tag, " trans"}, int'(bus.in_transition), int'(et));
        last_out = eo; last_src = es; last_trans = et;
    endtask

    // Idle cycles with wiggling inputs: nothing may change.
    task automatic idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.sample_valid = 1'b0;
            bus.alpha        = 1'($urandom);
            bus.hsnr_value   = W_HSNR'($urandom);
            bus.hdr_value    = W_HDR'($urandom);
            @(negedge clk);
            check({tag, " idle valid"}, int'(bus.out_valid), 0);
            check({tag, " idle out"},   int'(bus.out_value), last_out);
            check({tag, " idle src"},   int'(bus.out_source), int'(last_src));
            check({tag, " idle trans"}, int'(bus.in_transition), int'(last_trans));
        end
    endtask

    task automatic apply_reset(input string tag);
        bus.sample_valid = 1'b0;
        reset = 1'b0;
        #1;
        check({tag, " rst out"},   int'(bus.out_value), 0);
        check({tag, " rst valid"}, int'(bus.out_valid), 0);
        check({tag, " rst src"},   int'(bus.out_source), 0);
        check({tag, " rst trans"}, int'(bus.in_transition), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_hdr = 1'b0; m_fade = 0;
        last_out = 0; last_src = 1'b0; last_trans = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[$];
    bit   cur_alpha;

    initial begin
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.alpha = 1'b0;
        bus.hsnr_value = '0;
        bus.hdr_value = '0;

        // Directed table from reset: HSNR, switch, full fade, negative floor, abort, extremes.
        vecs.push_back('{1'b0,  100,   10,   100, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  100,   10,   100, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  100,   10,   100, 1'b0, 1'b0});
        vecs.push_back('{1'b1,  100,   10,    80, 1'b1, 1'b0});
        vecs.push_back('{1'b0,  100,   10,    85, 1'b1, 1'b1});
        vecs.push_back('{1'b0,  100,   10,    90, 1'b1, 1'b1});
        vecs.push_back('{1'b0,  100,   10,    95, 1'b1, 1'b1});
        vecs.push_back('{1'b0,  100,   10,   100, 1'b0, 1'b0});
        vecs.push_back('{1'b1,   -3,   -1,    -8, 1'b1, 1'b0});
        vecs.push_back('{1'b0,   -3,   -1,    -7, 1'b1, 1'b1});
        vecs.push_back('{1'b0,   -3,   -1,    -6, 1'b1, 1'b1});
        vecs.push_back('{1'b0,   -3,   -1,    -5, 1'b1, 1'b1});
        vecs.push_back('{1'b0,   -3,   -1,    -3, 1'b0, 1'b0});
        vecs.push_back('{1'b1,  100,   10,    80, 1'b1, 1'b0});
        vecs.push_back('{1'b0,  100,   10,    85, 1'b1, 1'b1});
        vecs.push_back('{1'b0,  100,   10,    90, 1'b1, 1'b1});
        vecs.push_back('{1'b1,  100,   10,    80, 1'b1, 1'b0});
        vecs.push_back('{1'b0,  100,   10,    85, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 2047,  255,  2040, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 2047, -256, -1025, 1'b1, 1'b1});

        // Reset state.
        @(negedge clk);
        check("reset out",   int'(bus.out_value), 0);
        check("reset valid", int'(bus.out_valid), 0);
        check("reset src",   int'(bus.out_source), 0);
        check("reset trans", int'(bus.in_transition), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            strobe($sformatf("vec%0d", i), vecs[i].alpha, vecs[i].hsnr, vecs[i].hdr,
                   1'b0, vecs[i].out, vecs[i].src, vecs[i].trans);
        end

        // Gaps mid-fade: alpha toggles without strobes must not advance the fade.
        idle("gap", 5);
        strobe("gap resume", 1'b0, 2047, -256, 1'b0, -1, 1'b1, 1'b1);

        // Reset mid-crossfade, then the first strobe follows HSNR rules.
        apply_reset("midfade");
        strobe("post reset", 1'b0, 5, 10, 1'b0, 5, 1'b0, 1'b0);
        strobe("post reset hdr", 1'b1, 5, 10, 1'b0, 80, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        cur_alpha = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur_alpha = ~cur_alpha;
            if ($urandom_range(0, 3) == 0) idle($sformatf("rnd%0d", i), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 99) == 0) apply_reset($sformatf("rnd%0d", i));
            strobe($sformatf("rnd%0d", i), cur_alpha,
                   int'($urandom_range(0, 4095)) - 2048,
                   int'($urandom_range(0, 511)) - 256,
                   1'b1, 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
